// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and packed-bus helpers for the multi-port register file.
package reg_file_pkg;

  localparam int ZERO_ADDR          = 0;
  localparam int MAX_READ           = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  // Widest packed bus and widest slice the helper below can handle.
  localparam int SLICE_BUS_W = 256;
  localparam int SLICE_W     = 64;

  // Returns field k of a packed bus whose fields are each 'width' bits wide.
  function automatic logic [SLICE_W-1:0] get_slice(
    input logic [SLICE_BUS_W-1:0] packed_bus,
    input int                     k,
    input int                     width
  );
    logic [SLICE_BUS_W-1:0] shifted;
    logic [SLICE_BUS_W-1:0] mask;
    shifted = packed_bus >> (k * width);
    mask    = (SLICE_BUS_W'(1) << width) - SLICE_BUS_W'(1);
    return SLICE_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read, write and reserve ports of the multi-port register file.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1
);

  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]  rd_data;
  logic [NUM_READ-1:0]             rd_busy;
  logic [NUM_WRITE-1:0]            wr_en;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
  logic                            rsv_en;
  logic [ADDR_WIDTH-1:0]           rsv_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: one busy bit per register, set at issue and cleared at writeback.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rsv_en,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ-1:0]             busy_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_ADDR);

  logic [DEPTH-1:0]      busy;
  logic [ADDR_WIDTH-1:0] wr_addr_v [NUM_WRITE];
  logic [ADDR_WIDTH-1:0] rd_addr_v [NUM_READ];
  logic                  rsv_ok;

  // Split the packed address buses and qualify the reserve (r0 can never be busy).
  always_comb begin
    for (int j = 0; j < NUM_WRITE; j++)
      wr_addr_v[j] = ADDR_WIDTH'(get_slice(SLICE_BUS_W'(wr_addr), j, ADDR_WIDTH));
    for (int k = 0; k < NUM_READ; k++)
      rd_addr_v[k] = ADDR_WIDTH'(get_slice(SLICE_BUS_W'(rd_addr), k, ADDR_WIDTH));
    rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == ZERO));
  end

  // Writes retire producers; a reserve in the same cycle is applied last so the newer producer stays outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++)
        if (wr_en[j]) busy[wr_addr_v[j]] <= 1'b0;
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end

  // Busy lookup for each read port.
  always_comb begin
    busy_out = '0;
    for (int k = 0; k < NUM_READ; k++)
      busy_out[k] = busy[rd_addr_v[k]] && !(ZERO_REG && (rd_addr_v[k] == ZERO));
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with write bypass, hardwired r0 and busy scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_ADDR);

  logic [DATA_WIDTH-1:0] regs      [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr_v [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wr_data_v [NUM_WRITE];
  logic [ADDR_WIDTH-1:0] rd_addr_v [NUM_READ];
  logic [DATA_WIDTH-1:0] rd_val    [NUM_READ];
  logic [NUM_READ-1:0]   rd_hit;
  logic [NUM_READ-1:0]   sb_busy;

  // Split the packed read/write buses into per-port fields.
  always_comb begin
    for (int j = 0; j < NUM_WRITE; j++) begin
      wr_addr_v[j] = ADDR_WIDTH'(get_slice(SLICE_BUS_W'(bus.wr_addr), j, ADDR_WIDTH));
      wr_data_v[j] = DATA_WIDTH'(get_slice(SLICE_BUS_W'(bus.wr_data), j, DATA_WIDTH));
    end
    for (int k = 0; k < NUM_READ; k++)
      rd_addr_v[k] = ADDR_WIDTH'(get_slice(SLICE_BUS_W'(bus.rd_addr), k, ADDR_WIDTH));
  end

  // Store enabled writes; higher ports are assigned later so they win an address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++)
        if (bus.wr_en[j] && !(ZERO_REG && (wr_addr_v[j] == ZERO)))
          regs[wr_addr_v[j]] <= wr_data_v[j];
    end
  end

  reg_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .busy_out (sb_busy)
  );

  // Read muxes: stored value, replaced by the highest matching same-cycle write; r0 and reset force zero.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_val[k] = regs[rd_addr_v[k]];
      rd_hit[k] = 1'b0;
      if (BYPASS) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (bus.wr_en[j] && (wr_addr_v[j] == rd_addr_v[k])) begin
            rd_hit[k] = 1'b1;
            rd_val[k] = wr_data_v[j];
          end
        end
      end
      if (!rst_n || (ZERO_REG && (rd_addr_v[k] == ZERO))) rd_val[k] = '0;
      bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_val[k];
      bus.rd_busy[k] = sb_busy[k] && !rd_hit[k];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: random and directed checks of two reg_file_mp configurations against an array model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int NR_A  = 3;
  localparam int NW_A  = 2;
  localparam int NR_B  = 2;
  localparam int NW_B  = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR_A), .NUM_WRITE(NW_A)) bus_a ();
  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR_B), .NUM_WRITE(NW_B)) bus_b ();

  reg_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR_A), .NUM_WRITE(NW_A),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  reg_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR_B), .NUM_WRITE(NW_B),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Stimulus shared by both DUTs; DUT B sees only write port 0 and read ports 0..1.
  logic [AW-1:0] rd_addr_s [NR_A];
  logic          wr_en_s   [NW_A];
  logic [AW-1:0] wr_addr_s [NW_A];
  logic [DW-1:0] wr_data_s [NW_A];
  logic          rsv_en_s;
  logic [AW-1:0] rsv_addr_s;

  // Reference model state.
  logic [DW-1:0] mem_a  [DEPTH];
  bit            busy_a [DEPTH];
  logic [DW-1:0] mem_b  [DEPTH];
  bit            busy_b [DEPTH];

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearStimulus();
    for (int k = 0; k < NR_A; k++) rd_addr_s[k] = '0;
    for (int j = 0; j < NW_A; j++) begin
      wr_en_s[j]   = 1'b0;
      wr_addr_s[j] = '0;
      wr_data_s[j] = '0;
    end
    rsv_en_s   = 1'b0;
    rsv_addr_s = '0;
  endtask

  task automatic readAll(input logic [AW-1:0] a);
    for (int k = 0; k < NR_A; k++) rd_addr_s[k] = a;
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < NR_A; k++) bus_a.rd_addr[k*AW +: AW] = rd_addr_s[k];
    for (int k = 0; k < NR_B; k++) bus_b.rd_addr[k*AW +: AW] = rd_addr_s[k];
    for (int j = 0; j < NW_A; j++) begin
      bus_a.wr_en[j]             = wr_en_s[j];
      bus_a.wr_addr[j*AW +: AW]  = wr_addr_s[j];
      bus_a.wr_data[j*DW +: DW]  = wr_data_s[j];
    end
    bus_b.wr_en[0]   = wr_en_s[0];
    bus_b.wr_addr    = wr_addr_s[0];
    bus_b.wr_data    = wr_data_s[0];
    bus_a.rsv_en     = rsv_en_s;
    bus_a.rsv_addr   = rsv_addr_s;
    bus_b.rsv_en     = rsv_en_s;
    bus_b.rsv_addr   = rsv_addr_s;
  endtask

  // Expected read value: zero in reset or for r0, else the last enabled write port hitting the address, else storage.
  function automatic logic [DW-1:0] expData(input bit bypass, input int nw, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!rst_n || a == 0) return '0;
    v = bypass ? mem_a[a] : mem_b[a];
    if (bypass)
      for (int j = 0; j < nw; j++)
        if (wr_en_s[j] && wr_addr_s[j] == a) v = wr_data_s[j];
    return v;
  endfunction

  function automatic logic [DW-1:0] expBusy(input bit bypass, input int nw, input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (bypass)
      for (int j = 0; j < nw; j++)
        if (wr_en_s[j] && wr_addr_s[j] == a) return '0;
    return bypass ? DW'(busy_a[a]) : DW'(busy_b[a]);
  endfunction

  task automatic compareAll();
    for (int k = 0; k < NR_A; k++) begin
      checkOutput($sformatf("a_data%0d_r%0d", k, rd_addr_s[k]), bus_a.rd_data[k*DW +: DW], expData(1'b1, NW_A, rd_addr_s[k]));
      checkOutput($sformatf("a_busy%0d_r%0d", k, rd_addr_s[k]), DW'(bus_a.rd_busy[k]), expBusy(1'b1, NW_A, rd_addr_s[k]));
    end
    for (int k = 0; k < NR_B; k++) begin
      checkOutput($sformatf("b_data%0d_r%0d", k, rd_addr_s[k]), bus_b.rd_data[k*DW +: DW], expData(1'b0, NW_B, rd_addr_s[k]));
      checkOutput($sformatf("b_busy%0d_r%0d", k, rd_addr_s[k]), DW'(bus_b.rd_busy[k]), expBusy(1'b0, NW_B, rd_addr_s[k]));
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0; busy_a[i] = 1'b0;
      mem_b[i] = '0; busy_b[i] = 1'b0;
    end
  endtask

  // Model state change at a clock edge: writes land and retire producers, then reserves mark busy.
  task automatic updateModel();
    if (!rst_n) begin
      clearModel();
      return;
    end
    for (int j = 0; j < NW_A; j++)
      if (wr_en_s[j]) begin
        if (wr_addr_s[j] != 0) mem_a[wr_addr_s[j]] = wr_data_s[j];
        busy_a[wr_addr_s[j]] = 1'b0;
      end
    if (wr_en_s[0]) begin
      if (wr_addr_s[0] != 0) mem_b[wr_addr_s[0]] = wr_data_s[0];
      busy_b[wr_addr_s[0]] = 1'b0;
    end
    if (rsv_en_s && rsv_addr_s != 0) begin
      busy_a[rsv_addr_s] = 1'b1;
      busy_b[rsv_addr_s] = 1'b1;
    end
  endtask

  task automatic driveAndCheck();
    applyStimulus();
    @(negedge clk);
    compareAll();
  endtask

  task automatic advance();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    clearStimulus();
    rst_n = 1'b0;
    applyStimulus();
    #1;

    // Reset held with active writes and reserves: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      wr_en_s[0] = 1'b1; wr_addr_s[0] = AW'(i + 4); wr_data_s[0] = $urandom;
      wr_en_s[1] = 1'b1; wr_addr_s[1] = AW'(i + 8); wr_data_s[1] = $urandom;
      rsv_en_s = 1'b1;   rsv_addr_s = AW'(i + 4);
      rd_addr_s[0] = wr_addr_s[0]; rd_addr_s[1] = wr_addr_s[1]; rd_addr_s[2] = rsv_addr_s;
      driveAndCheck();
      checkOutput("reset_bypass_data", bus_a.rd_data[0 +: DW], 32'h0);
      advance();
    end

    // Release: contents written during reset were discarded.
    rst_n = 1'b1;
    clearStimulus();
    for (int i = 0; i < 3; i++) begin
      rd_addr_s[0] = AW'(i + 4); rd_addr_s[1] = AW'(i + 8); rd_addr_s[2] = AW'(i + 4);
      driveAndCheck();
      checkOutput("post_reset_busy", DW'(bus_a.rd_busy[0]), 32'h0);
      advance();
    end

    // Write r5: bypassed in the same cycle on A, visible a cycle later on B.
    clearStimulus();
    wr_en_s[0] = 1'b1; wr_addr_s[0] = 5'd5; wr_data_s[0] = 32'hDEADBEEF;
    readAll(5'd5);
    driveAndCheck();
    checkOutput("r5_bypass_a", bus_a.rd_data[0 +: DW], 32'hDEADBEEF);
    checkOutput("r5_old_b", bus_b.rd_data[0 +: DW], 32'h0);
    advance();
    clearStimulus(); readAll(5'd5);
    driveAndCheck();
    checkOutput("r5_stored_b", bus_b.rd_data[0 +: DW], 32'hDEADBEEF);
    advance();

    // r0 ignores writes and reserves.
    clearStimulus();
    wr_en_s[0] = 1'b1; wr_addr_s[0] = 5'd0; wr_data_s[0] = 32'h12345678;
    rsv_en_s = 1'b1; rsv_addr_s = 5'd0;
    readAll(5'd0);
    driveAndCheck();
    advance();
    for (int i = 0; i < 2; i++) begin
      clearStimulus(); readAll(5'd0);
      driveAndCheck();
      checkOutput("r0_data", bus_a.rd_data[0 +: DW], 32'h0);
      checkOutput("r0_busy", DW'(bus_a.rd_busy[1]), 32'h0);
      advance();
    end

    // Dual write conflict on r7: port 1 wins.
    clearStimulus();
    wr_en_s[0] = 1'b1; wr_addr_s[0] = 5'd7; wr_data_s[0] = 32'h1;
    wr_en_s[1] = 1'b1; wr_addr_s[1] = 5'd7; wr_data_s[1] = 32'h2;
    readAll(5'd7);
    driveAndCheck();
    checkOutput("r7_conflict_bypass", bus_a.rd_data[2*DW +: DW], 32'h2);
    advance();
    clearStimulus(); readAll(5'd7);
    driveAndCheck();
    checkOutput("r7_conflict_stored", bus_a.rd_data[0 +: DW], 32'h2);
    advance();

    // Scoreboard on r9: reserve, retire, reserve+write together.
    clearStimulus(); rsv_en_s = 1'b1; rsv_addr_s = 5'd9; readAll(5'd9);
    driveAndCheck();
    checkOutput("r9_rsv_same_cycle", DW'(bus_a.rd_busy[0]), 32'h0);
    advance();
    clearStimulus(); readAll(5'd9);
    driveAndCheck();
    checkOutput("r9_busy_a", DW'(bus_a.rd_busy[0]), 32'h1);
    checkOutput("r9_busy_b", DW'(bus_b.rd_busy[0]), 32'h1);
    advance();
    clearStimulus(); wr_en_s[0] = 1'b1; wr_addr_s[0] = 5'd9; wr_data_s[0] = 32'hA5; readAll(5'd9);
    driveAndCheck();
    checkOutput("r9_wb_busy_bypass", DW'(bus_a.rd_busy[1]), 32'h0);
    advance();
    clearStimulus(); readAll(5'd9);
    driveAndCheck();
    checkOutput("r9_retired", DW'(bus_b.rd_busy[1]), 32'h0);
    advance();
    clearStimulus(); wr_en_s[0] = 1'b1; wr_addr_s[0] = 5'd9; wr_data_s[0] = 32'h5A;
    rsv_en_s = 1'b1; rsv_addr_s = 5'd9; readAll(5'd9);
    driveAndCheck();
    advance();
    clearStimulus(); readAll(5'd9);
    driveAndCheck();
    checkOutput("r9_rsv_wins", DW'(bus_a.rd_busy[0]), 32'h1);
    checkOutput("r9_new_data", bus_a.rd_data[0 +: DW], 32'h5A);
    advance();

    // Asynchronous reset between edges with r3 written and busy.
    clearStimulus(); wr_en_s[0] = 1'b1; wr_addr_s[0] = 5'd3; wr_data_s[0] = 32'h55;
    rsv_en_s = 1'b1; rsv_addr_s = 5'd3; readAll(5'd3);
    driveAndCheck();
    advance();
    clearStimulus(); readAll(5'd3);
    driveAndCheck();
    checkOutput("r3_before_reset_data", bus_a.rd_data[0 +: DW], 32'h55);
    checkOutput("r3_before_reset_busy", DW'(bus_a.rd_busy[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("r3_async_data", bus_a.rd_data[0 +: DW], 32'h0);
    checkOutput("r3_async_busy", DW'(bus_a.rd_busy[0]), 32'h0);
    checkOutput("r3_async_data_b", bus_b.rd_data[0 +: DW], 32'h0);
    compareAll();
    advance();
    rst_n = 1'b1;
    clearStimulus(); readAll(5'd3);
    driveAndCheck();
    advance();

    // Random traffic with occasional resets, over a narrow address range to force collisions.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < NR_A; k++) rd_addr_s[k] = AW'($urandom_range(0, 15));
      for (int j = 0; j < NW_A; j++) begin
        wr_en_s[j]   = $urandom_range(0, 1) == 1;
        wr_addr_s[j] = AW'($urandom_range(0, 15));
        wr_data_s[j] = $urandom;
      end
      rsv_en_s   = $urandom_range(0, 2) == 0;
      rsv_addr_s = AW'($urandom_range(0, 15));
      driveAndCheck();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the pipelined MIPS core, replacing the fixed 2-read/1-write file. It adds configurable read/write port counts, same-cycle write-to-read bypass, a hardwired-zero r0, asynchronous clear, and a per-register busy scoreboard. The decode stage uses the scoreboard for hazard detection, and writeback drives the write ports.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- NUM_READ, 2, read ports (1..4)
- NUM_WRITE, 1, write ports (1..2)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, and is never busy
- BYPASS, 1, 1: a same-cycle write is visible on reads
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k is at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, combinational
- rd_busy  out  NUM_READ  1 = addressed register has a pending producer
- wr_en  in  NUM_WRITE  per-port write enable
- wr_addr  in  NUM_WRITE*ADDR_WIDTH  packed write addresses
- wr_data  in  NUM_WRITE*DATA_WIDTH  packed write data
- rsv_en  in  1  reserve a destination at issue
- rsv_addr  in  ADDR_WIDTH  register to mark busy

## Operation
- Reset (rst_n low, asynchronous): all registers are 0 and all busy bits are 0. rd_data and rd_busy therefore read 0 during reset.
- Write: on posedge with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Two ports writing the same address: the higher port index wins.
- Read: rd_data[k] = reg[rd_addr[k]].
  - With ZERO_REG=1, address 0 always returns 0.
  - With BYPASS=1, if any enabled write port targets rd_addr[k] this cycle, rd_data[k] returns that port's wr_data (highest index wins).
- Scoreboard: one busy bit per register.
  - rsv_en sets busy[rsv_addr] at posedge. The set is ignored for address 0 when ZERO_REG=1.
  - Any enabled write clears busy[wr_addr] at posedge.
  - Reserve and write to the same address in one cycle: the set wins (the newer producer is still outstanding).
  - Reserving an already-busy register leaves it busy. One outstanding producer per register is tracked; the in-order pipeline guarantees this.
- rd_busy[k] = busy[rd_addr[k]].
  - With BYPASS=1, it is forced to 0 when a same-cycle write targets rd_addr[k], since the data is already on rd_data.
  - rd_busy is not affected by a same-cycle rsv_en.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency: data is stored at the next posedge. With BYPASS=0 it is readable the cycle after the write; with BYPASS=1 it is readable in the same cycle.
- Busy update: visible on rd_busy the cycle after rsv_en or the write.
- Reset mid-operation: a pending write or reserve in the reset cycle is discarded. The first capturing edge is the first posedge after rst_n deasserts.
- There are no handshakes; all inputs are sampled every posedge.

## Structure
- Package reg_file_pkg holds:
  - constants ZERO_ADDR = 0 and MAX_READ = 4;
  - a function that extracts packed slice k;
  - defaults for DATA_WIDTH and ADDR_WIDTH.
- Sub-module reg_file_scoreboard: busy-bit array with set/clear priority and lookup for NUM_READ ports, parametrised on ADDR_WIDTH, NUM_READ, NUM_WRITE, and ZERO_REG.
- Top level: storage array, write-priority logic, and the bypass muxes.

## Test plan
- Reset: hold rst_n low, drive writes -> every rd_data = 0 and rd_busy = 0. Release -> register contents are still 0.
- Write then read: write 0xDEADBEEF to r5. The same cycle (BYPASS=1) reads 0xDEADBEEF. Repeat with BYPASS=0: the same cycle returns the old value 0, and the next cycle returns 0xDEADBEEF.
- r0: write 0x12345678 to r0 and reserve r0 -> reads 0, rd_busy 0 in all following cycles.
- Dual write conflict (NUM_WRITE=2): port 0 writes 0x1 and port 1 writes 0x2 to r7 -> bypass and the stored value are both 0x2.
- Scoreboard: reserve r9, then read the next cycle -> rd_busy = 1.
  - Write r9 = 0xA5 -> rd_busy = 0 that cycle (bypass) and afterwards.
  - Reserve and write r9 together -> r9 = new data and busy = 1 the next cycle.
- Async reset mid-run: pull rst_n low between edges with r3 = 0x55 and busy[3] = 1 -> both clear immediately, without a clock edge.
